// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC-driven instruction fetch over a req/ack memory port,
// handing instructions to decode with a valid/ready handshake.
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_fault
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_discard;
    logic               r_imem_req;
    logic [31:0]        r_imem_addr;
    logic               r_if_valid;
    logic [31:0]        r_if_instr;
    logic [31:0]        r_if_pc;
    logic               r_fetch_fault;

    logic               w_timeout;
    logic               w_misaligned;

    assign w_timeout    = (r_wait_cnt == TIMEOUT_LAST);
    assign w_misaligned = (pc[1:0] != 2'b00);

    // PC advances only on the cycle decode takes a non-flushed instruction
    assign pc_en = (r_state == S_FULL) & id_ready & ~flush;

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign fetch_fault = r_fetch_fault;

    // Fetch sequencer: issue request, wait for ack/timeout, hold for decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_discard     <= 1'b0;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= '0;
            r_if_valid    <= 1'b0;
            r_if_instr    <= '0;
            r_if_pc       <= '0;
            r_fetch_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!(r_fetch_fault || flush)) begin
                        if (w_misaligned) begin
                            r_fetch_fault <= 1'b1;
                        end else begin
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= pc;
                            r_wait_cnt  <= '0;
                            r_discard   <= 1'b0;
                            r_state     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        // ack beats a same-cycle timeout; flushed data is dropped
                        r_imem_req <= 1'b0;
                        if (r_discard || flush) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_if_instr <= imem_rdata;
                            r_if_pc    <= r_imem_addr;
                            r_if_valid <= 1'b1;
                            r_state    <= S_FULL;
                        end
                    end else begin
                        // request is never withdrawn on flush, only marked stale
                        if (flush) begin
                            r_discard <= 1'b1;
                        end
                        if (w_timeout) begin
                            r_imem_req    <= 1'b0;
                            r_fetch_fault <= 1'b1;
                            r_state       <= S_IDLE;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FULL: begin
                    if (flush || id_ready) begin
                        r_if_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// transactions scored against a transaction-level outcome model.
module tb_instr_fetch_unit;

    localparam int unsigned TO = 4;

    typedef enum int {OUT_DELIVER, OUT_DROP, OUT_TIMEOUT, OUT_MISALIGN} outcome_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;

    int n_tests;
    int n_fail;

    instr_fetch_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_en       (pc_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a scenario loses sync with the DUT
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction outcome from memory delay (WAIT-cycle index of ack) and flush point
    function automatic outcome_t predict(input logic [31:0] a, input int d, input int fl_wait);
        if (a[1:0] != 2'b00) return OUT_MISALIGN;
        if (d >= int'(TO)) return OUT_TIMEOUT;
        if (fl_wait >= 0 && fl_wait <= d) return OUT_DROP;
        return OUT_DELIVER;
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_req"},   32'(imem_req),    32'd0);
        check_val({tag, "_addr"},  imem_addr,        32'd0);
        check_val({tag, "_valid"}, 32'(if_valid),    32'd0);
        check_val({tag, "_instr"}, if_instr,         32'd0);
        check_val({tag, "_ifpc"},  if_pc,            32'd0);
        check_val({tag, "_fault"}, 32'(fetch_fault), 32'd0);
        check_val({tag, "_pcen"},  32'(pc_en),       32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1; flush = 1'b0; imem_ack = 1'b0; id_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("rst");
        rst = 1'b0; id_ready = 1'b0;
    endtask

    // One fetch transaction; entered/left at posedge+1 with the unit idle
    task automatic fetch_txn(input logic [31:0] a, input int d, input int bp,
                             input int fl_wait, input bit fl_full,
                             input logic [31:0] data, output outcome_t oc);
        int n;
        oc = predict(a, d, fl_wait);
        pc = a; flush = 1'b0; id_ready = 1'($urandom); imem_ack = 1'($urandom);
        imem_rdata = $urandom;
        #1 check_val("idle_pcen", 32'(pc_en), 32'd0);
        @(posedge clk); #1;
        imem_ack = 1'b0;
        if (oc == OUT_MISALIGN) begin
            check_val("mis_req",   32'(imem_req),    32'd0);
            check_val("mis_fault", 32'(fetch_fault), 32'd1);
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                check_val("mis_noreq", 32'(imem_req), 32'd0);
            end
            return;
        end
        check_val("launch_req",  32'(imem_req), 32'd1);
        check_val("launch_addr", imem_addr,     a);
        n = (d < int'(TO)) ? d : int'(TO) - 1;
        for (int k = 0; k <= n; k++) begin
            imem_ack   = (k == d);
            imem_rdata = (k == d) ? data : $urandom;
            flush      = (k == fl_wait);
            id_ready   = 1'($urandom);
            #1;
            check_val("wait_pcen",  32'(pc_en),    32'd0);
            check_val("wait_req",   32'(imem_req), 32'd1);
            check_val("wait_addr",  imem_addr,     a);
            check_val("wait_valid", 32'(if_valid), 32'd0);
            @(posedge clk); #1;
            imem_ack = 1'b0; flush = 1'b0; id_ready = 1'b0;
        end
        case (oc)
            OUT_TIMEOUT: begin
                check_val("to_req",   32'(imem_req),    32'd0);
                check_val("to_fault", 32'(fetch_fault), 32'd1);
                check_val("to_valid", 32'(if_valid),    32'd0);
                @(posedge clk); #1;
                check_val("to_noreq", 32'(imem_req), 32'd0);
            end
            OUT_DROP: begin
                check_val("drop_req",   32'(imem_req),    32'd0);
                check_val("drop_valid", 32'(if_valid),    32'd0);
                check_val("drop_fault", 32'(fetch_fault), 32'd0);
            end
            default: begin
                check_val("full_valid", 32'(if_valid), 32'd1);
                check_val("full_instr", if_instr,      data);
                check_val("full_pc",    if_pc,         a);
                check_val("full_req",   32'(imem_req), 32'd0);
                for (int b = 0; b < bp; b++) begin
                    id_ready = 1'b0; imem_ack = 1'($urandom); imem_rdata = $urandom;
                    #1;
                    check_val("bp_pcen", 32'(pc_en), 32'd0);
                    @(posedge clk); #1;
                    imem_ack = 1'b0;
                    check_val("bp_valid", 32'(if_valid), 32'd1);
                    check_val("bp_instr", if_instr,      data);
                    check_val("bp_pc",    if_pc,         a);
                    check_val("bp_req",   32'(imem_req), 32'd0);
                end
                id_ready = 1'b1; flush = fl_full;
                #1 check_val(fl_full ? "ffl_pcen" : "xfer_pcen", 32'(pc_en), fl_full ? 32'd0 : 32'd1);
                @(posedge clk); #1;
                id_ready = 1'b0; flush = 1'b0;
                check_val("post_valid", 32'(if_valid), 32'd0);
                check_val("post_pcen",  32'(pc_en),    32'd0);
                check_val("post_req",   32'(imem_req), 32'd0);
            end
        endcase
    endtask

    // Reset asserted mid-transaction: outputs must clear without a clock edge
    task automatic reset_mid(input bit in_full, input logic [31:0] a, input logic [31:0] nxt);
        pc = a; flush = 1'b0; imem_ack = 1'b0; id_ready = 1'b0;
        @(posedge clk); #1;
        check_val("rm_req", 32'(imem_req), 32'd1);
        if (in_full) begin
            imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            imem_ack = 1'b0;
            check_val("rm_valid", 32'(if_valid), 32'd1);
        end
        id_ready = in_full ? 1'b0 : 1'b1;
        #2 rst = 1'b1;
        #1 check_all_zero(in_full ? "rmf" : "rmw");
        id_ready = 1'b0;
        #1 rst = 1'b0; pc = nxt;
        @(posedge clk); #1;
        check_val("rm_resume_req",  32'(imem_req), 32'd1);
        check_val("rm_resume_addr", imem_addr,     nxt);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        check_val("rm_resume_instr", if_instr, 32'h1234_5678);
        id_ready = 1'b1;
        @(posedge clk); #1;
        id_ready = 1'b0;
    endtask

    initial begin
        outcome_t oc;
        logic [31:0] a;
        int d, bp, fw;
        bit ff;
        n_tests = 0; n_fail = 0;
        rst = 1'b1; pc = '0; imem_ack = 1'b0; imem_rdata = '0; flush = 1'b0; id_ready = 1'b0;
        #1 check_all_zero("por");
        apply_reset();

        // Basic fetch
        fetch_txn(32'h0000_0040, 0, 0, -1, 1'b0, 32'h2008_0005, oc);
        // Back-to-back fetch, then 5-cycle backpressure
        fetch_txn(32'h0000_0044, 1, 5, -1, 1'b0, 32'hA5A5_0001, oc);
        // Flush in WAIT, ack three cycles later
        fetch_txn(32'h0000_0100, 3, 0, 0, 1'b0, 32'h0BAD_0BAD, oc);
        // Flush in FULL with id_ready high
        fetch_txn(32'h0000_0200, 0, 2, -1, 1'b1, 32'hC0DE_0002, oc);
        // Ack on last legal WAIT cycle
        fetch_txn(32'h0000_0300, int'(TO) - 1, 0, -1, 1'b0, 32'h7777_0003, oc);
        // Timeout
        fetch_txn(32'h0000_0400, int'(TO), 0, -1, 1'b0, 32'h0, oc);
        apply_reset();
        // Misaligned PC
        fetch_txn(32'h0000_0042, 0, 0, -1, 1'b0, 32'h0, oc);
        apply_reset();
        // Reset in WAIT and in FULL
        reset_mid(1'b0, 32'h0000_0500, 32'h0000_0600);
        reset_mid(1'b1, 32'h0000_0700, 32'h0000_0800);

        // Randomized transactions
        for (int t = 0; t < 60; t++) begin
            a = $urandom;
            a[1:0] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            d  = ($urandom_range(0, 7) < 6) ? int'($urandom_range(0, TO - 1))
                                             : int'($urandom_range(TO, TO + 1));
            bp = int'($urandom_range(0, 3));
            fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO - 1)) : -1;
            ff = ($urandom_range(0, 4) == 0);
            fetch_txn(a, d, bp, fw, ff, $urandom, oc);
            if (oc == OUT_TIMEOUT || oc == OUT_MISALIGN) apply_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
